// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture
//   Avalon-MM input PIO for slow external inputs: limit switches, encoder flags
//   and buttons. Each input bit passes through a two-flop synchroniser, then a
//   debouncer, then an edge detector. Detected edges are latched in a
//   write-1-to-clear register, and a maskable level interrupt is raised from it.
//   Zero-wait-state slave.
//
//   Register map
//     0 DATA         read  : debounced input value (writes ignored)
//     1 DIRECTION    read  : always 0 (writes ignored)
//     2 IRQMASK      r/w   : bits [WIDTH-1:0]
//     3 EDGECAPTURE  r/w1c : captured edges
//
//   Ports
//     clk         system clock
//     reset       synchronous, active-high reset
//     address     register select
//     chipselect  slave select (qualifies writes only)
//     write_n     active-low write strobe
//     writedata   write data
//     in_port     asynchronous external inputs
//     readdata    read data, zero-extended, combinational from address
//     irq         level interrupt, OR of masked captured edges
module pio_in_edge_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0    // 0 rising, 1 falling, 2 any
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Values 0 and 1 both disable filtering; the counter still exists as a
  // single bit so the port-level structure does not change with the parameter.
  localparam bit FILTER_EN = (DEBOUNCE_CYCLES > 1);
  localparam int CNT_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = FILTER_EN ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0]            s1_q, s1_d;
  logic [WIDTH-1:0]            s2_q, s2_d;
  logic [WIDTH-1:0]            db_q, db_d;
  logic [WIDTH-1:0]            db_dly_q, db_dly_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            irqmask_q, irqmask_d;
  logic [WIDTH-1:0]            edgecapture_q, edgecapture_d;

  logic             wr_en;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] ec_clr;

  // Upper writedata bits have no destination when WIDTH < 32.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign s1_d     = in_port;
  assign s2_d     = s1_q;
  assign db_dly_d = db_q;

  // Debouncer: db follows s2 only after s2 has differed from it on
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!FILTER_EN) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0) begin
      edge_hit = db_q & ~db_dly_q;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~db_q & db_dly_q;
    end else begin
      edge_hit = db_q ^ db_dly_q;
    end
  end

  assign wr_en = chipselect && !write_n;

  // A clear and a new edge in the same cycle leave the bit set, so an edge is
  // never lost to a racing acknowledge.
  always_comb begin
    irqmask_d = irqmask_q;
    ec_clr    = '0;
    if (wr_en && (address == ADDR_MASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      ec_clr = writedata[WIDTH-1:0];
    end
    edgecapture_d = (edgecapture_q & ~ec_clr) | edge_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      db_q          <= '0;
      db_dly_q      <= '0;
      cnt_q         <= '0;
      irqmask_q     <= '0;
      edgecapture_q <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      db_q          <= db_d;
      db_dly_q      <= db_dly_d;
      cnt_q         <= cnt_d;
      irqmask_q     <= irqmask_d;
      edgecapture_q <= edgecapture_d;
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_DATA: readdata = 32'(db_q);
      ADDR_DIR:  readdata = 32'h0;
      ADDR_MASK: readdata = 32'(irqmask_q);
      ADDR_EDGE: readdata = 32'(edgecapture_q);
      default:   readdata = 32'h0;
    endcase
  end

  assign irq = |(edgecapture_q & irqmask_q);

endmodule

// File: doc/pio_in_edge_capture.md
# pio_in_edge_capture

Avalon-MM slave input PIO: the read-side counterpart of the motor output PIO on the Nios II system bus. Samples a `WIDTH`-bit external input port (limit switches, encoder flags, buttons) through:
- a two-flop synchroniser,
- a per-bit debouncer,
- a per-bit edge detector.

It latches detected edges in a write-1-to-clear register and raises a maskable level interrupt to the CPU. It is a zero-wait-state slave on the same register map style as the output PIO.

## Interface

Parameters:
- `WIDTH`, 4, number of input bits (1..32).
- `DEBOUNCE_CYCLES`, 16, number of consecutive clock cycles a synchronised bit must differ from its debounced value before the debounced value updates. 0 and 1 both mean no filtering.
- `EDGE_TYPE`, 0, edge to capture: 0 = rising, 1 = falling, 2 = any.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `readdata`  out  32  read data, zero-extended.
- `irq`  out  1  level interrupt request.

## Operation

Register map (a write occurs only when `chipselect && !write_n`):
- Address 0, DATA: read returns the debounced value. Writes are ignored.
- Address 1, DIRECTION: reads 0. Writes are ignored.
- Address 2, IRQMASK: read/write, bits `[WIDTH-1:0]`.
- Address 3, EDGECAPTURE: read returns captured edges. Writing 1 to a bit clears that bit; writing 0 leaves it unchanged.

Read path:
- `readdata` is combinational from `address` and the registers, independent of `chipselect`.
- Bits `[31:WIDTH]` read as 0.

Per-bit datapath:
- Synchroniser: `s1 <= in_port`, `s2 <= s1`.
- Debouncer, counter `cnt` of `max(1, clog2(DEBOUNCE_CYCLES))` bits:
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - When `DEBOUNCE_CYCLES <= 1`: `db <= s2` every cycle.
- Edge detect:
  - `db_d <= db`.
  - rise = `db & ~db_d`; fall = `~db & db_d`; any = `db ^ db_d`.
  - `EDGE_TYPE` selects which of these is the edge signal.
- Capture: `edgecapture[i] <= 1` on edge. On a write-1-clear in the same cycle as an edge, the set wins and the bit stays 1.
- `irq = |(edgecapture & irqmask)`, combinational from registers, so it is glitch-free.

Reset behaviour:
- `s1`, `s2`, `db`, `db_d`, `cnt`, `irqmask` and `edgecapture` all clear to 0.
- Consequently `irq` = 0 and DATA reads 0.
- An input held at 1 through reset is not falsely captured as a rising edge for the first `DEBOUNCE_CYCLES+1` cycles after reset. It is then captured once as a genuine rising edge.
- Reset asserted mid-debounce discards any partial count.

## Timing

- An input change sampled into `s1` at clock edge k:
  - `db` updates at edge k+1+max(1, N), where N = `DEBOUNCE_CYCLES`.
  - DATA shows the new value from that edge onward.
  - `edgecapture` sets one edge later.
  - `irq` rises in the same cycle `edgecapture` sets, provided the mask bit is 1.
- Glitch rejection: a pulse on `s2` shorter than N cycles never changes `db` and never sets `edgecapture`.
- Register writes:
  - An IRQMASK write takes effect at the next edge.
  - `irq` follows in the same cycle as that edge (combinational).
  - A clear of the only pending masked bit drops `irq` after the write edge.
- Reads have zero wait states: `readdata` is valid in the same cycle `address` is presented.
- All bits are independent. Simultaneous edges on several bits all capture in the same cycle.

## Test plan

- **Reset:** after reset, all four addresses read 0x00000000 and `irq` = 0. Write 0xF to address 0, then read address 0: still 0.
- **Debounce latency:** with defaults, raise `in_port[0]` just before edge k.
  - DATA reads 0x1 from edge k+17.
  - `edgecapture` = 0x1 from edge k+18.
  - `irq` stays 0 while mask = 0.
- **Glitch reject:** pulse `in_port[2]` high for 10 cycles → DATA stays 0x0, EDGECAPTURE stays 0x0. A 20-cycle pulse → EDGECAPTURE = 0x4.
- **Mask and clear:**
  - Mask = 0x2, edge on bit 1 → `irq` = 1.
  - Write 0x1 to address 3 → `irq` stays 1.
  - Write 0x2 → EDGECAPTURE reads 0 and `irq` = 0 after the write edge.
- **Set-wins collision:** time a write of 0x8 to address 3 to coincide with a bit-3 edge → bit 3 remains 1.
- **Reset mid-operation and `EDGE_TYPE`:**
  - Assert reset 8 cycles into a debounce → no update afterwards until a full 16-cycle window completes.
  - With `EDGE_TYPE`=1, a 1→0 transition captures and a 0→1 transition does not.
